watch_core_multi: RTL and testbench

Parametrised timekeeping core for the IC watch, succeeding the single-alarm control block. Runs time-of-day from a 1 Hz tick enable. Provides a background stopwatch with lap capture and N_ALARM independently enabled alarms with a timed ring output. Sits between the button/mode decoder (debounced single-cycle pulses) and the 7-segment display mux.

---
 rtl/watch_pkg.sv | 31 +++
 rtl/watch_core_multi_if.sv | 39 +++
 rtl/hms_counter.sv | 57 +++++
 rtl/watch_core_multi.sv | 175 +++++++++++++++++
 tb/tb_watch_core_multi.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared field limits, mode encoding and helpers for the watch core
package watch_pkg;

  localparam int FW = 8;

  localparam logic [FW-1:0] SEC_MAX  = 8'd59;
  localparam logic [FW-1:0] MIN_MAX  = 8'd59;
  localparam logic [FW-1:0] HOUR_MAX = 8'd23;

  typedef enum logic [2:0] {
    MODE_RUN   = 3'd0,
    MODE_SET_H = 3'd1,
    MODE_SET_M = 3'd2,
    MODE_SET_S = 3'd3,
    MODE_SW    = 3'd4,
    MODE_ALM_M = 3'd5,
    MODE_ALM_H = 3'd6,
    MODE_RSVD  = 3'd7
  } mode_t;

  typedef enum logic {
    RING_IDLE = 1'b0,
    RING_ON   = 1'b1
  } ring_state_t;

  // >= rather than == so an out-of-range value recovers to 0
  function automatic logic [FW-1:0] wrap_inc(input logic [FW-1:0] v, input logic [FW-1:0] lim);
    return (v >= lim) ? '0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/watch_core_multi_if.sv
// rtl/watch_core_multi_if.sv - button/display-side bundle of the watch core
interface watch_core_multi_if import watch_pkg::*; #(
  parameter int N_ALARM = 4
);
  localparam int AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic              tick;
  logic [2:0]        mode;
  logic              hold;
  logic              clr;
  logic              inc;
  logic [AW-1:0]     alm_sel;
  logic [N_ALARM-1:0] alm_en;
  logic              sw_ss;
  logic              sw_zero;
  logic              sw_lap;
  logic              ack;

  logic [FW-1:0]     hour, min, sec;
  logic [FW-1:0]     sw_hour, sw_min, sw_sec;
  logic [FW-1:0]     lap_hour, lap_min, lap_sec;
  logic [FW-1:0]     ahour, amin;
  logic              sw_run;
  logic              ring;
  logic [AW-1:0]     ring_id;

  modport master (
    output tick, mode, hold, clr, inc, alm_sel, alm_en, sw_ss, sw_zero, sw_lap, ack,
    input  hour, min, sec, sw_hour, sw_min, sw_sec, lap_hour, lap_min, lap_sec,
    input  ahour, amin, sw_run, ring, ring_id
  );

  modport slave (
    input  tick, mode, hold, clr, inc, alm_sel, alm_en, sw_ss, sw_zero, sw_lap, ack,
    output hour, min, sec, sw_hour, sw_min, sw_sec, lap_hour, lap_min, lap_sec,
    output ahour, amin, sw_run, ring, ring_id
  );

endinterface

// File: rtl/hms_counter.sv
// rtl/hms_counter.sv - h:m:s counter with clear, parallel load and carry chain
module hms_counter import watch_pkg::*; #(
  parameter int HMAX = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [FW-1:0] lh,
  input  logic [FW-1:0] lm,
  input  logic [FW-1:0] ls,
  output logic [FW-1:0] h,
  output logic [FW-1:0] m,
  output logic [FW-1:0] s,
  output logic [FW-1:0] nh,
  output logic [FW-1:0] nm,
  output logic [FW-1:0] ns,
  output logic          wrap
);

  localparam logic [FW-1:0] HLIM = HMAX[FW-1:0];

  // next value is exposed so the alarm matcher can compare post-increment time
  always_comb begin
    ns = wrap_inc(s, SEC_MAX);
    nm = m;
    nh = h;
    if (s >= SEC_MAX) begin
      nm = wrap_inc(m, MIN_MAX);
      if (m >= MIN_MAX) nh = wrap_inc(h, HLIM);
    end
  end

  assign wrap = en && (s >= SEC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (clr) begin
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (load) begin
      h <= lh;
      m <= lm;
      s <= ls;
    end else if (en) begin
      h <= nh;
      m <= nm;
      s <= ns;
    end
  end

endmodule

// File: rtl/watch_core_multi.sv
// rtl/watch_core_multi.sv - time of day, stopwatch with lap, N alarms with timed ring
module watch_core_multi import watch_pkg::*; #(
  parameter int N_ALARM     = 4,
  parameter int RING_SECS   = 60,
  parameter int SW_HOUR_MAX = 99
) (
  input logic              clk,
  input logic              rst_n,
  watch_core_multi_if.slave bus
);

  localparam int AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;
  localparam logic [FW-1:0] RING_LOAD = RING_SECS[FW-1:0];

  mode_t         md;
  logic          set_mode;
  logic          tod_en, tod_load, tod_wrap;
  logic [FW-1:0] tod_h, tod_m, tod_s, tod_nh, tod_nm, tod_ns;
  logic [FW-1:0] ld_h, ld_m, ld_s;

  assign md       = mode_t'(bus.mode);
  assign set_mode = (md == MODE_SET_H) || (md == MODE_SET_M) || (md == MODE_SET_S);

  // clr and hold both suppress advance so neither can raise the carry used by the matcher
  assign tod_en   = bus.tick && !set_mode && !bus.hold && !bus.clr;
  assign tod_load = bus.inc && set_mode && !bus.hold && !bus.clr;

  assign ld_h = (md == MODE_SET_H) ? wrap_inc(tod_h, HOUR_MAX) : tod_h;
  assign ld_m = (md == MODE_SET_M) ? wrap_inc(tod_m, MIN_MAX)  : tod_m;
  assign ld_s = (md == MODE_SET_S) ? wrap_inc(tod_s, SEC_MAX)  : tod_s;

  hms_counter #(.HMAX(23)) u_tod (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tod_en),
    .clr  (bus.clr),
    .load (tod_load),
    .lh   (ld_h),
    .lm   (ld_m),
    .ls   (ld_s),
    .h    (tod_h),
    .m    (tod_m),
    .s    (tod_s),
    .nh   (tod_nh),
    .nm   (tod_nm),
    .ns   (tod_ns),
    .wrap (tod_wrap)
  );

  assign bus.hour = tod_h;
  assign bus.min  = tod_m;
  assign bus.sec  = tod_s;

  // stopwatch ignores hold/clr and mode entirely
  logic          sw_run_q;
  logic [FW-1:0] sw_h, sw_m, sw_s, sw_nh, sw_nm, sw_ns;
  logic          sw_wrap;
  logic [FW-1:0] lap_h, lap_m, lap_s;

  hms_counter #(.HMAX(SW_HOUR_MAX)) u_sw (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sw_run_q && bus.tick),
    .clr  (bus.sw_zero),
    .load (1'b0),
    .lh   ('0),
    .lm   ('0),
    .ls   ('0),
    .h    (sw_h),
    .m    (sw_m),
    .s    (sw_s),
    .nh   (sw_nh),
    .nm   (sw_nm),
    .ns   (sw_ns),
    .wrap (sw_wrap)
  );

  logic unused_sw;
  assign unused_sw = ^{sw_nh, sw_nm, sw_ns, sw_wrap, tod_ns};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_run_q <= 1'b0;
      lap_h    <= '0;
      lap_m    <= '0;
      lap_s    <= '0;
    end else begin
      if (bus.sw_zero)    sw_run_q <= 1'b0;
      else if (bus.sw_ss) sw_run_q <= !sw_run_q;
      if (bus.sw_lap) begin
        lap_h <= sw_h;
        lap_m <= sw_m;
        lap_s <= sw_s;
      end
    end
  end

  assign bus.sw_hour  = sw_h;
  assign bus.sw_min   = sw_m;
  assign bus.sw_sec   = sw_s;
  assign bus.sw_run   = sw_run_q;
  assign bus.lap_hour = lap_h;
  assign bus.lap_min  = lap_m;
  assign bus.lap_sec  = lap_s;

  logic [FW-1:0] ahr [N_ALARM];
  logic [FW-1:0] amn [N_ALARM];
  logic          sel_ok;

  assign sel_ok = (32'(bus.alm_sel) < 32'(N_ALARM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ALARM; i++) begin
        ahr[i] <= '0;
        amn[i] <= '0;
      end
    end else if (bus.inc && sel_ok) begin
      if (md == MODE_ALM_H) ahr[bus.alm_sel] <= wrap_inc(ahr[bus.alm_sel], HOUR_MAX);
      if (md == MODE_ALM_M) amn[bus.alm_sel] <= wrap_inc(amn[bus.alm_sel], MIN_MAX);
    end
  end

  assign bus.ahour = sel_ok ? ahr[bus.alm_sel] : '0;
  assign bus.amin  = sel_ok ? amn[bus.alm_sel] : '0;

  logic [N_ALARM-1:0] hit;
  logic [AW-1:0]      win;
  logic               any_hit;

  for (genvar i = 0; i < N_ALARM; i++) begin : g_match
    assign hit[i] = tod_wrap && bus.alm_en[i] && (tod_nh == ahr[i]) && (tod_nm == amn[i]);
  end

  always_comb begin
    win = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (hit[i]) win = AW'(i);
    end
  end

  assign any_hit = |hit;

  ring_state_t   rstate;
  logic [FW-1:0] ring_cnt;
  logic          ring_q;
  logic [AW-1:0] ring_id_q;

  // a fresh match takes precedence over ack, expiry and enable drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate    <= RING_IDLE;
      ring_cnt  <= '0;
      ring_q    <= 1'b0;
      ring_id_q <= '0;
    end else if (any_hit) begin
      rstate    <= RING_ON;
      ring_cnt  <= RING_LOAD;
      ring_q    <= 1'b1;
      ring_id_q <= win;
    end else if (rstate == RING_ON) begin
      if (bus.ack || !bus.alm_en[ring_id_q] || (bus.tick && ring_cnt <= 8'd1)) begin
        rstate   <= RING_IDLE;
        ring_cnt <= '0;
        ring_q   <= 1'b0;
      end else if (bus.tick) begin
        ring_cnt <= ring_cnt - 8'd1;
      end
    end
  end

  assign bus.ring    = ring_q;
  assign bus.ring_id = ring_id_q;

endmodule

// File: tb/tb_watch_core_multi.sv
// tb/tb_watch_core_multi.sv - directed table and sequence checks for watch_core_multi
module tb_watch_core_multi;
  import watch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   nchk = 0;

  watch_core_multi_if #(.N_ALARM(4)) bus ();

  watch_core_multi #(.N_ALARM(4), .RING_SECS(3), .SW_HOUR_MAX(99)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [2:0] mode;
    logic       hold, clr, inc, ss, zero;
    logic [7:0] eh, em, es, ess;
    logic       erun;
  } vec_t;

  function automatic vec_t mkv(int t, int md, int h, int c, int i, int ss, int z,
                               int eh, int em, int es, int ess, int er);
    vec_t v;
    v.tick = 1'(t);  v.mode = 3'(md); v.hold = 1'(h); v.clr = 1'(c);
    v.inc = 1'(i);   v.ss = 1'(ss);   v.zero = 1'(z);
    v.eh = 8'(eh);   v.em = 8'(em);   v.es = 8'(es);  v.ess = 8'(ess);
    v.erun = 1'(er);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.tick = 0; bus.mode = MODE_RUN; bus.hold = 0; bus.clr = 0; bus.inc = 0;
    bus.sw_ss = 0; bus.sw_zero = 0; bus.sw_lap = 0; bus.ack = 0;
  endtask

  task automatic do_tick();
    bus.tick = 1; cycle(); bus.tick = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.clr = 1; cycle(); bus.clr = 0;
    bus.mode = MODE_SET_H; bus.inc = 1; repeat (h) cycle();
    bus.mode = MODE_SET_M; repeat (m) cycle();
    bus.mode = MODE_SET_S; repeat (s) cycle();
    idle_in();
  endtask

  task automatic set_alarm(input int sel, input int h, input int m);
    bus.alm_sel = 2'(sel);
    bus.mode = MODE_ALM_H; bus.inc = 1; repeat (h) cycle();
    bus.mode = MODE_ALM_M; repeat (m) cycle();
    idle_in();
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour"}, bus.hour, h);
    chk({name, ".min"},  bus.min,  m);
    chk({name, ".sec"},  bus.sec,  s);
  endtask

  vec_t vt[$];

  initial begin
    idle_in();
    bus.alm_sel = '0;
    bus.alm_en  = '0;

    repeat (2) cycle();
    chk_time("reset", 0, 0, 0);
    chk("reset.sw", {bus.sw_hour, bus.sw_min, bus.sw_sec}, 0);
    chk("reset.lap", {bus.lap_hour, bus.lap_min, bus.lap_sec}, 0);
    chk("reset.ring", {bus.ring, bus.ring_id, bus.sw_run}, 0);
    chk("reset.alarm", {bus.ahour, bus.amin}, 0);
    rst_n = 1;

    set_time(23, 59, 58);
    chk_time("preset", 23, 59, 58);

    //          tk mode        hd cl in ss zr  h  m  s sws run
    vt.push_back(mkv(1, MODE_RUN,   0, 0, 0, 0, 0, 23, 59, 59, 0, 0));
    vt.push_back(mkv(1, MODE_RUN,   0, 0, 0, 0, 0,  0,  0,  0, 0, 0));
    vt.push_back(mkv(0, MODE_SET_H, 0, 0, 1, 0, 0,  1,  0,  0, 0, 0));
    vt.push_back(mkv(1, MODE_SET_H, 0, 0, 0, 0, 0,  1,  0,  0, 0, 0));
    vt.push_back(mkv(0, MODE_SET_M, 0, 0, 1, 0, 0,  1,  1,  0, 0, 0));
    vt.push_back(mkv(1, MODE_SET_S, 0, 0, 1, 0, 0,  1,  1,  1, 0, 0));
    vt.push_back(mkv(1, MODE_RSVD,  0, 0, 0, 0, 0,  1,  1,  2, 0, 0));
    vt.push_back(mkv(1, MODE_RUN,   1, 0, 0, 0, 0,  1,  1,  2, 0, 0));
    vt.push_back(mkv(1, MODE_RUN,   1, 1, 0, 0, 0,  0,  0,  0, 0, 0));
    vt.push_back(mkv(0, MODE_SET_H, 1, 0, 1, 0, 0,  0,  0,  0, 0, 0));
    vt.push_back(mkv(1, MODE_RUN,   0, 0, 0, 1, 0,  0,  0,  1, 0, 1));
    vt.push_back(mkv(1, MODE_SW,    0, 0, 0, 0, 0,  0,  0,  2, 1, 1));
    vt.push_back(mkv(1, MODE_RUN,   1, 0, 0, 0, 0,  0,  0,  2, 2, 1));
    vt.push_back(mkv(1, MODE_RUN,   0, 1, 0, 0, 0,  0,  0,  0, 3, 1));
    vt.push_back(mkv(1, MODE_RUN,   0, 0, 0, 1, 0,  0,  0,  1, 4, 0));
    vt.push_back(mkv(1, MODE_RUN,   0, 0, 0, 0, 0,  0,  0,  2, 4, 0));
    vt.push_back(mkv(0, MODE_ALM_M, 0, 0, 0, 1, 0,  0,  0,  2, 4, 1));
    vt.push_back(mkv(0, MODE_RUN,   0, 0, 0, 1, 1,  0,  0,  2, 0, 0));
    vt.push_back(mkv(1, MODE_ALM_H, 0, 0, 0, 0, 0,  0,  0,  3, 0, 0));

    foreach (vt[k]) begin
      bus.tick = vt[k].tick; bus.mode = vt[k].mode; bus.hold = vt[k].hold;
      bus.clr = vt[k].clr; bus.inc = vt[k].inc; bus.sw_ss = vt[k].ss; bus.sw_zero = vt[k].zero;
      cycle();
      idle_in();
      chk_time($sformatf("vec%0d", k), vt[k].eh, vt[k].em, vt[k].es);
      chk($sformatf("vec%0d.sw_sec", k), bus.sw_sec, vt[k].ess);
      chk($sformatf("vec%0d.sw_run", k), bus.sw_run, vt[k].erun);
      chk($sformatf("vec%0d.ring", k), bus.ring, 0);
    end

    // set-mode wraps without carry
    set_time(23, 45, 12);
    bus.mode = MODE_SET_H; bus.inc = 1; cycle(); idle_in();
    chk_time("seth_wrap", 0, 45, 12);
    set_time(0, 59, 30);
    bus.mode = MODE_SET_M; bus.inc = 1; cycle(); idle_in();
    chk_time("setm_wrap", 0, 0, 30);
    set_time(5, 10, 59);
    bus.mode = MODE_SET_S; bus.inc = 1; cycle(); idle_in();
    chk_time("sets_wrap", 5, 10, 0);

    // two slots at the same time, lowest index wins
    set_alarm(1, 7, 30);
    set_alarm(3, 7, 30);
    bus.alm_sel = 2'd1; #1;
    chk("alm1.read", {bus.ahour, bus.amin}, {8'd7, 8'd30});
    bus.alm_sel = 2'd2; #1;
    chk("alm2.read", {bus.ahour, bus.amin}, 0);
    bus.alm_en = 4'b1110;
    set_time(0, 0, 0);
    chk("clr_no_match", bus.ring, 0);
    bus.alm_en = 4'b1010;
    set_time(7, 29, 59);
    chk("set_no_match", bus.ring, 0);
    do_tick();
    chk_time("match", 7, 30, 0);
    chk("match.ring", bus.ring, 1);
    chk("match.id", bus.ring_id, 1);
    do_tick(); chk("ring_t1", bus.ring, 1);
    do_tick(); chk("ring_t2", bus.ring, 1);
    do_tick(); chk("ring_t3", bus.ring, 0);

    // rematch while ringing with ack in the same cycle
    set_time(7, 29, 59);
    do_tick();
    chk("re.ring", bus.ring, 1);
    do_tick();
    set_alarm(0, 7, 30);
    bus.alm_en = 4'b1011;
    set_time(7, 29, 59);
    chk("re.held", bus.ring, 1);
    bus.ack = 1; do_tick(); bus.ack = 0;
    chk("re.ack_match", bus.ring, 1);
    chk("re.id", bus.ring_id, 0);
    do_tick(); chk("re.t1", bus.ring, 1);
    do_tick(); chk("re.t2", bus.ring, 1);
    do_tick(); chk("re.t3", bus.ring, 0);

    set_time(7, 29, 59);
    do_tick();
    chk("ack.pre", bus.ring, 1);
    bus.ack = 1; cycle(); bus.ack = 0;
    chk("ack.fall", bus.ring, 0);
    set_time(7, 29, 59);
    do_tick();
    chk("endrop.pre", bus.ring, 1);
    bus.alm_en = 4'b1010; cycle();
    chk("endrop.fall", bus.ring, 0);

    // stopwatch with lap taken on the clearing cycle
    bus.alm_en = '0;
    bus.sw_zero = 1; cycle(); idle_in();
    bus.sw_ss = 1; cycle(); idle_in();
    repeat (65) do_tick();
    chk("sw65", {bus.sw_hour, bus.sw_min, bus.sw_sec}, {8'd0, 8'd1, 8'd5});
    chk("sw65.run", bus.sw_run, 1);
    bus.sw_lap = 1; bus.sw_zero = 1; cycle(); idle_in();
    chk("lap", {bus.lap_hour, bus.lap_min, bus.lap_sec}, {8'd0, 8'd1, 8'd5});
    chk("lap.sw", {bus.sw_hour, bus.sw_min, bus.sw_sec}, 0);
    chk("lap.run", bus.sw_run, 0);

    // hold freezes time but not the stopwatch
    bus.clr = 1; cycle(); idle_in();
    bus.sw_ss = 1; cycle(); idle_in();
    bus.hold = 1;
    repeat (5) begin bus.tick = 1; cycle(); bus.tick = 0; end
    bus.hold = 0;
    chk_time("hold", 0, 0, 0);
    chk("hold.sw", bus.sw_sec, 5);

    // asynchronous reset mid-ring and mid-run
    bus.alm_en = 4'b1010;
    set_time(7, 29, 59);
    do_tick();
    chk("rst.pre", {bus.ring, bus.sw_run}, 2'b11);
    rst_n = 0;
    #1;
    chk("rst.ring", bus.ring, 0);
    chk("rst.run", bus.sw_run, 0);
    chk_time("rst", 0, 0, 0);
    chk("rst.sw", bus.sw_sec, 0);
    cycle();
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
